mmu_feeder_nxn: RTL and testbench
=================================

// Module: mmu_feeder_nxn
// PURPOSE
//  Parametrised operand feeder and result serialiser for an NxN output-stationary systolic MMU.
//  Latches an NxN input matrix A and weight matrix B on start, and drives diagonally skewed rows of A / columns of B into the array.
//  After a fixed drain it snapshots all NxN results and streams them row-major to the host over a valid/ready port.
//  Sits between the memory module (operands), the MMU (a/b/clear, c) and the host output path.
// PARAMETERS
//  N       2  array dimension (>=2)
//  DW      8  element width, operands and results
//  DRAIN   2  cycles after last feed cycle before results are valid in c_flat (>=1)
// PORTS
//  clk            in   1        clock, all state on posedge
//  rst            in   1        asynchronous, active-high reset
//  start          in   1        job request; accepted only when start_ready=1
//  start_ready    out  1        feeder can accept start this cycle
//  busy           out  1        any job in FEED/DRAIN/WAIT/OUT
//  done           out  1        1-cycle pulse: last result of a job accepted by host
//  input_flat     in   N*N*DW   A[i][k] at [(i*N+k)*DW +: DW]
//  weight_flat    in   N*N*DW   B[k][j] at [(k*N+j)*DW +: DW]
//  c_flat         in   N*N*DW   MMU results C[i][j], same packing
//  clear          out  1        MMU accumulator clear
//  a_data         out  N*DW     row-i operand at [i*DW +: DW]
//  b_data         out  N*DW     column-j operand at [j*DW +: DW]
//  host_valid     out  1        host_outdata valid
//  host_ready     in   1        host accepts when valid&ready
//  host_outdata   out  DW       current result element
//  host_last      out  1        marks C[N-1][N-1]
// BEHAVIOUR
//  Reset: state IDLE, clear=1, a_data=b_data=0, host_valid=0, host_outdata=0, host_last=0, done=0, counters 0.
//  Feed FSM: IDLE -> FEED (2N-1 cyc) -> DRAIN (DRAIN cyc) -> [WAIT] -> IDLE.
//   start&start_ready: latch input_flat/weight_flat into operand regs; next cycle FEED t=0. Host may change inputs after.
//   FEED cycle t (0..2N-2), registered: a_data[i]=A[i][t-i], b_data[j]=B[t-j][j] if 0<=t-i<N / 0<=t-j<N, else 0.
//   clear=0 from FEED t=0 through the capture cycle; clear=1 otherwise. a_data=b_data=0 outside FEED.
//   DRAIN end: if output buffer free, copy c_flat into buffer (capture), go IDLE; else WAIT, capture when buffer frees.
//  Output FSM: OIDLE -> OUT -> OIDLE.
//   Capture -> OUT, idx=0. host_valid=1, host_outdata=buf[idx], host_last=(idx==N*N-1).
//   valid&ready: idx++ next cycle; on last element: host_valid=0 next cycle, done=1 one cycle, buffer free.
//   host_valid held and data stable while ready=0 (no drop, no duplicate). Capture and free in same cycle allowed.
//  start_ready: feed FSM IDLE and (overlap rules below). start while !start_ready ignored, not queued.
//  busy = feed FSM!=IDLE or output FSM!=OIDLE.
//  Widths: idx and feed counters sized $clog2(N*N+1) / $clog2(2N); no arithmetic on data, pass-through only.
//  Reset mid-job: all state discarded, outputs to reset values within the reset assertion; no done pulse.
// CONFIGURATION
//  MMU_FEEDER_OVERLAP_EN defined: start_ready = feed IDLE; new job may feed while previous job streams out; WAIT state used when second capture arrives before buffer frees.
//  Undefined: start_ready = feed IDLE and output OIDLE (fully serial jobs); WAIT unreachable.
// TESTING  (N=2, DW=8, DRAIN=2; A=[[1,2],[3,4]], B=[[5,6],[7,8]], model C=[[19,22],[43,50]])
//  1 Reset then start -> FEED a/b: t0 a=(1,0) b=(5,0); t1 a=(2,3) b=(7,6); t2 a=(0,4) b=(0,8); then zeros, clear low t0..capture.
//  2 host_ready=1 constant -> host_outdata 19,22,43,50 on 4 consecutive cycles, host_last on 50, done pulse next cycle.
//  3 host_ready toggled 1,0,0,1,... -> sequence unchanged 19,22,43,50; data/valid stable during stalls.
//  4 start pulsed during FEED and (without OVERLAP) during OUT -> ignored; exactly one result stream, one done.
//  5 OVERLAP_EN, second job A=B=identity started in first OUT with host_ready=0 -> WAIT entered; final stream 19,22,43,50,1,0,0,1.
//  6 rst asserted mid-OUT -> next cycle host_valid=0, clear=1, busy=0; fresh start yields correct full stream.

Source files
------------

// File: rtl/mmu_feeder_nxn.sv
// Operand feeder / result serialiser for an NxN output-stationary systolic MMU.
// Latency: start -> first skewed operands next cycle; results stream 2N-1+DRAIN+1 cycles after start.
// Backpressure: host_ready stalls the stream with valid/data held; a full result buffer parks the feed FSM in WAIT.
// Optional build macro MMU_FEEDER_OVERLAP_EN lets a new job feed while the previous one streams out.
module mmu_feeder_nxn #(
    parameter int N     = 2,
    parameter int DW    = 8,
    parameter int DRAIN = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                start_ready,
    output logic                busy,
    output logic                done,
    input  logic [N*N*DW-1:0]   input_flat,
    input  logic [N*N*DW-1:0]   weight_flat,
    input  logic [N*N*DW-1:0]   c_flat,
    output logic                clear,
    output logic [N*DW-1:0]     a_data,
    output logic [N*DW-1:0]     b_data,
    output logic                host_valid,
    input  logic                host_ready,
    output logic [DW-1:0]       host_outdata,
    output logic                host_last
);

    localparam int NN  = N * N;
    localparam int TW  = $clog2(2 * N);
    localparam int IW  = $clog2(NN + 1);
    localparam int DCW = (DRAIN > 1) ? $clog2(DRAIN) : 1;

    localparam logic [TW-1:0]  T_LAST = TW'(2 * N - 2);
    localparam logic [DCW-1:0] D_LAST = DCW'(DRAIN - 1);
    localparam logic [IW-1:0]  I_LAST = IW'(NN - 1);

    typedef enum logic [1:0] {F_IDLE, F_FEED, F_DRAIN, F_WAIT} fstate_t;
    typedef enum logic       {O_IDLE, O_OUT} ostate_t;

    fstate_t              fstate;
    ostate_t              ostate;
    logic [NN*DW-1:0]     op_a;
    logic [NN*DW-1:0]     op_b;
    logic [NN*DW-1:0]     res_buf;
    logic [TW-1:0]        tcnt;
    logic [DCW-1:0]       dcnt;
    logic [IW-1:0]        idx;

    logic                 start_ok;
    logic                 xfer;
    logic                 buf_free;
    logic                 capture;

    // Row i of A enters the array delayed by i cycles: a[i] = A[i][t-i].
    function automatic logic [N*DW-1:0] skew_a(input logic [NN*DW-1:0] m, input int t);
        logic [N*DW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            if ((t - i) >= 0 && (t - i) < N)
                r[i*DW +: DW] = m[(i*N + (t - i))*DW +: DW];
        end
        return r;
    endfunction

    // Column j of B enters the array delayed by j cycles: b[j] = B[t-j][j].
    function automatic logic [N*DW-1:0] skew_b(input logic [NN*DW-1:0] m, input int t);
        logic [N*DW-1:0] r;
        r = '0;
        for (int j = 0; j < N; j++) begin
            if ((t - j) >= 0 && (t - j) < N)
                r[j*DW +: DW] = m[((t - j)*N + j)*DW +: DW];
        end
        return r;
    endfunction

`ifdef MMU_FEEDER_OVERLAP_EN
    assign start_ready = (fstate == F_IDLE);
`else
    assign start_ready = (fstate == F_IDLE) && (ostate == O_IDLE);
`endif

    assign busy     = (fstate != F_IDLE) || (ostate != O_IDLE);
    assign start_ok = start && start_ready;
    assign xfer     = (ostate == O_OUT) && host_valid && host_ready;
    // Buffer counts as free on the very edge its last element leaves, so a
    // waiting job can capture back-to-back with no bubble.
    assign buf_free = (ostate == O_IDLE) || (xfer && (idx == I_LAST));
    assign capture  = (((fstate == F_DRAIN) && (dcnt == D_LAST)) || (fstate == F_WAIT)) && buf_free;

    // Feed FSM: latch operands, drive skewed operands, drain, then hand results to the buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fstate <= F_IDLE;
            tcnt   <= '0;
            dcnt   <= '0;
            op_a   <= '0;
            op_b   <= '0;
            a_data <= '0;
            b_data <= '0;
            clear  <= 1'b1;
        end else begin
            case (fstate)
                F_IDLE: begin
                    if (start_ok) begin
                        // Operands come straight from the ports this edge so FEED t=0
                        // is already on a_data/b_data in the first FEED cycle.
                        op_a   <= input_flat;
                        op_b   <= weight_flat;
                        a_data <= skew_a(input_flat, 0);
                        b_data <= skew_b(weight_flat, 0);
                        clear  <= 1'b0;
                        tcnt   <= '0;
                        fstate <= F_FEED;
                    end
                end
                F_FEED: begin
                    if (tcnt == T_LAST) begin
                        a_data <= '0;
                        b_data <= '0;
                        dcnt   <= '0;
                        fstate <= F_DRAIN;
                    end else begin
                        tcnt   <= tcnt + 1'b1;
                        a_data <= skew_a(op_a, int'(tcnt) + 1);
                        b_data <= skew_b(op_b, int'(tcnt) + 1);
                    end
                end
                F_DRAIN: begin
                    if (dcnt == D_LAST) begin
                        if (buf_free) begin
                            clear  <= 1'b1;
                            fstate <= F_IDLE;
                        end else begin
                            fstate <= F_WAIT;
                        end
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                F_WAIT: begin
                    // Accumulators hold (clear low, zero operands) until the buffer frees.
                    if (buf_free) begin
                        clear  <= 1'b1;
                        fstate <= F_IDLE;
                    end
                end
                default: fstate <= F_IDLE;
            endcase
        end
    end

    // Output FSM: snapshot results and stream them row-major under valid/ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ostate       <= O_IDLE;
            idx          <= '0;
            res_buf      <= '0;
            host_valid   <= 1'b0;
            host_outdata <= '0;
            host_last    <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            if (xfer && (idx == I_LAST)) begin
                ostate     <= O_IDLE;
                host_valid <= 1'b0;
                host_last  <= 1'b0;
                done       <= 1'b1;
            end else if (xfer) begin
                idx          <= idx + 1'b1;
                host_outdata <= res_buf[(int'(idx) + 1)*DW +: DW];
                host_last    <= ((idx + 1'b1) == I_LAST);
            end
            // A capture on the same edge as the final transfer starts the next stream.
            if (capture) begin
                res_buf      <= c_flat;
                ostate       <= O_OUT;
                idx          <= '0;
                host_valid   <= 1'b1;
                host_outdata <= c_flat[DW-1:0];
                host_last    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mmu_feeder_nxn.sv
// Directed bench for mmu_feeder_nxn (N=2, DW=8, DRAIN=2) with a small 2x2
// output-stationary systolic array model driving c_flat from a_data/b_data/clear.
// Build with MMU_FEEDER_OVERLAP_EN defined to exercise the overlapped-job path.
module tb_mmu_feeder_nxn;

    logic        clk;
    logic        rst;
    logic        start;
    logic        start_ready;
    logic        busy;
    logic        done;
    logic [31:0] input_flat;
    logic [31:0] weight_flat;
    logic [31:0] c_flat;
    logic        clear;
    logic [15:0] a_data;
    logic [15:0] b_data;
    logic        host_valid;
    logic        host_ready;
    logic [7:0]  host_outdata;
    logic        host_last;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;

    logic [7:0] exp_q [8];
    logic [7:0] exp_l;
    logic       pat [4];

    // A=[[1,2],[3,4]], B=[[5,6],[7,8]] packed as element (r*2+c)
    localparam logic [31:0] MAT_A = {8'd4, 8'd3, 8'd2, 8'd1};
    localparam logic [31:0] MAT_B = {8'd8, 8'd7, 8'd6, 8'd5};
    localparam logic [31:0] MAT_I = {8'd1, 8'd0, 8'd0, 8'd1};

    mmu_feeder_nxn #(.N(2), .DW(8), .DRAIN(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .start_ready  (start_ready),
        .busy         (busy),
        .done         (done),
        .input_flat   (input_flat),
        .weight_flat  (weight_flat),
        .c_flat       (c_flat),
        .clear        (clear),
        .a_data       (a_data),
        .b_data       (b_data),
        .host_valid   (host_valid),
        .host_ready   (host_ready),
        .host_outdata (host_outdata),
        .host_last    (host_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // 2x2 systolic array model: a flows right, b flows down, PE(i,j) accumulates a*b.
    logic [7:0] ain [2][2];
    logic [7:0] bin [2][2];
    logic [7:0] ar  [2][2];
    logic [7:0] br  [2][2];
    logic [7:0] acc [2][2];

    always_comb begin
        ain[0][0] = a_data[7:0];
        ain[0][1] = ar[0][0];
        ain[1][0] = a_data[15:8];
        ain[1][1] = ar[1][0];
        bin[0][0] = b_data[7:0];
        bin[0][1] = b_data[15:8];
        bin[1][0] = br[0][0];
        bin[1][1] = br[0][1];
    end

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                if (rst) begin
                    ar[i][j]  <= 8'd0;
                    br[i][j]  <= 8'd0;
                    acc[i][j] <= 8'd0;
                end else begin
                    ar[i][j] <= ain[i][j];
                    br[i][j] <= bin[i][j];
                    if (clear) acc[i][j] <= 8'd0;
                    else       acc[i][j] <= acc[i][j] + ain[i][j] * bin[i][j];
                end
            end
        end
    end

    assign c_flat = {acc[1][1], acc[1][0], acc[0][1], acc[0][0]};

    always @(posedge clk) begin
        if (done) done_cnt++;
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag);
        int w = 0;
        while (!host_valid && w < 40) begin
            step();
            w++;
        end
        chk({tag, "_valid_timeout"}, {31'd0, host_valid}, 32'd1);
    endtask

    // Receive n elements; mode 0 keeps ready high, mode 1 uses the 1,0,0,1 pattern.
    // Data/last/valid are checked every cycle, so stalls also check stability.
    task automatic recv(input int n, input int mode, input string tag);
        int p = 0;
        for (int k = 0; k < n; k++) begin
            bit got = 1'b0;
            int guard = 0;
            wait_valid(tag);
            while (!got && guard < 20) begin
                logic rd;
                rd = (mode == 0) ? 1'b1 : pat[p % 4];
                p++;
                host_ready = rd;
                chk({tag, "_valid"}, {31'd0, host_valid}, 32'd1);
                chk({tag, "_data"}, {24'd0, host_outdata}, {24'd0, exp_q[k]});
                chk({tag, "_last"}, {31'd0, host_last}, {31'd0, exp_l[k]});
                step();
                if (rd) got = 1'b1;
                guard++;
            end
        end
        host_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        rst = 1'b1;
        start = 1'b0;
        host_ready = 1'b0;
        input_flat = MAT_A;
        weight_flat = MAT_B;

        // Reset state
        step(); step();
        chk("rst_clear", {31'd0, clear}, 32'd1);
        chk("rst_a", {16'd0, a_data}, 32'd0);
        chk("rst_b", {16'd0, b_data}, 32'd0);
        chk("rst_valid", {31'd0, host_valid}, 32'd0);
        chk("rst_data", {24'd0, host_outdata}, 32'd0);
        chk("rst_last", {31'd0, host_last}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_sready", {31'd0, start_ready}, 32'd1);

        // Test 1/2: skewed feed and streaming with ready held high
        rst = 1'b0;
        host_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        input_flat = 32'hFFFF_FFFF;
        weight_flat = 32'hFFFF_FFFF;
        chk("t0_a", {16'd0, a_data}, 32'h0001);
        chk("t0_b", {16'd0, b_data}, 32'h0005);
        chk("t0_clear", {31'd0, clear}, 32'd0);
        chk("t0_busy", {31'd0, busy}, 32'd1);
        chk("t0_sready", {31'd0, start_ready}, 32'd0);
        start = 1'b1;
        step();
        chk("t1_a", {16'd0, a_data}, 32'h0302);
        chk("t1_b", {16'd0, b_data}, 32'h0607);
        start = 1'b0;
        input_flat = MAT_A;
        weight_flat = MAT_B;
        step();
        chk("t2_a", {16'd0, a_data}, 32'h0400);
        chk("t2_b", {16'd0, b_data}, 32'h0800);
        chk("t2_clear", {31'd0, clear}, 32'd0);
        step();
        chk("dr0_a", {16'd0, a_data}, 32'd0);
        chk("dr0_b", {16'd0, b_data}, 32'd0);
        chk("dr0_clear", {31'd0, clear}, 32'd0);
        step();
        chk("dr1_clear", {31'd0, clear}, 32'd0);
        chk("dr1_valid", {31'd0, host_valid}, 32'd0);
        step();
        chk("o0_valid", {31'd0, host_valid}, 32'd1);
        chk("o0_data", {24'd0, host_outdata}, 32'd19);
        chk("o0_last", {31'd0, host_last}, 32'd0);
        chk("o0_clear", {31'd0, clear}, 32'd1);
`ifndef MMU_FEEDER_OVERLAP_EN
        chk("o0_sready", {31'd0, start_ready}, 32'd0);
        start = 1'b1;
`endif
        step();
        start = 1'b0;
        chk("o1_data", {24'd0, host_outdata}, 32'd22);
        step();
        chk("o2_data", {24'd0, host_outdata}, 32'd43);
        chk("o2_last", {31'd0, host_last}, 32'd0);
        step();
        chk("o3_data", {24'd0, host_outdata}, 32'd50);
        chk("o3_last", {31'd0, host_last}, 32'd1);
        step();
        chk("o4_valid", {31'd0, host_valid}, 32'd0);
        chk("o4_done", {31'd0, done}, 32'd1);
        step();
        chk("o5_done", {31'd0, done}, 32'd0);
        chk("o5_busy", {31'd0, busy}, 32'd0);
        chk("o5_sready", {31'd0, start_ready}, 32'd1);
        chk("t2_done_cnt", done_cnt, 32'd1);
        step(); step(); step();
        chk("t4_no_extra_job", {31'd0, busy}, 32'd0);

        // Test 3: ready toggling 1,0,0,1
        exp_q[0] = 8'd19; exp_q[1] = 8'd22; exp_q[2] = 8'd43; exp_q[3] = 8'd50;
        exp_q[4] = 8'd1;  exp_q[5] = 8'd0;  exp_q[6] = 8'd0;  exp_q[7] = 8'd1;
        exp_l = 8'b1000_1000;
        host_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        recv(4, 1, "t3");
        step();
        chk("t3_done_cnt", done_cnt, 32'd2);
        chk("t3_busy", {31'd0, busy}, 32'd0);

`ifdef MMU_FEEDER_OVERLAP_EN
        // Test 5: second job overlaps the first stream and parks in WAIT
        start = 1'b1;
        step();
        start = 1'b0;
        wait_valid("t5_first");
        chk("t5_sready", {31'd0, start_ready}, 32'd1);
        input_flat = MAT_I;
        weight_flat = MAT_I;
        start = 1'b1;
        step();
        start = 1'b0;
        input_flat = MAT_A;
        weight_flat = MAT_B;
        for (int i = 0; i < 8; i++) step();
        chk("t5_wait_sready", {31'd0, start_ready}, 32'd0);
        chk("t5_wait_clear", {31'd0, clear}, 32'd0);
        chk("t5_wait_valid", {31'd0, host_valid}, 32'd1);
        recv(8, 1, "t5");
        step();
        chk("t5_done_cnt", done_cnt, 32'd4);
        chk("t5_busy", {31'd0, busy}, 32'd0);
`endif

        // Test 6: reset mid-stream, then a fresh job
        d0 = done_cnt;
        host_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_valid("t6_first");
        step();
        rst = 1'b1;
        step();
        chk("t6_valid", {31'd0, host_valid}, 32'd0);
        chk("t6_clear", {31'd0, clear}, 32'd1);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_data", {24'd0, host_outdata}, 32'd0);
        rst = 1'b0;
        step();
        chk("t6_no_done", done_cnt, d0);
        start = 1'b1;
        step();
        start = 1'b0;
        recv(4, 0, "t6");
        step();
        chk("t6_done_cnt", done_cnt, d0 + 1);
        chk("t6_busy_end", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
